// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access stage: decoded load/store flags, FSM states,
// access widths and byte-lane strobe constants.
package mem_access_pkg;

    typedef struct packed {
        logic lb;
        logic lh;
        logic lw;
        logic lbu;
        logic lhu;
        logic sb;
        logic sh;
        logic sw;
    } control_info;

    typedef enum logic {
        IDLE,
        MEM
    } mem_state_t;

    typedef enum logic [1:0] {
        WIDTH_BYTE,
        WIDTH_HALF,
        WIDTH_WORD
    } mem_width_t;

    localparam logic [3:0] WSTRB_NONE    = 4'b0000;
    localparam logic [3:0] WSTRB_BYTE    = 4'b0001;
    localparam logic [3:0] WSTRB_HALF_LO = 4'b0011;
    localparam logic [3:0] WSTRB_HALF_HI = 4'b1100;
    localparam logic [3:0] WSTRB_WORD    = 4'b1111;

endpackage

// File: rtl/mem_access_load_extend.sv
// Aligns a read word to the addressed byte lane and sign- or zero-extends
// the selected byte/halfword to 32 bits.
module mem_access_load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  mem_width_t  i_width,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = i_rdata >> {i_offset, 3'b000};
        unique case (i_width)
            WIDTH_BYTE: o_data = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
            WIDTH_HALF: o_data = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
            default:    o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues data-memory requests for loads/stores,
// passes other results through, and flags misaligned accesses and bus timeouts.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  control_info CTR_INFO,
    input  logic [31:0] ALU_RESULT,
    input  logic [31:0] RS2_VAL,
    input  logic [4:0]  IN_RD,
    input  logic        IN_WE,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [3:0]  MEM_WSTRB,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,
    output logic        OUT_VALID,
    output logic [4:0]  OUT_RD,
    output logic [31:0] OUT_DATA,
    output logic        OUT_WE,
    output logic        MISALIGNED,
    output logic        BUS_ERROR
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_t  r_state;
    logic        r_inReady;
    logic        r_memReq;
    logic        r_memWe;
    logic [31:0] r_memAddr;
    logic [3:0]  r_memWstrb;
    logic [31:0] r_memWdata;
    logic [1:0]  r_offset;
    mem_width_t  r_width;
    logic        r_signed;
    logic        r_isLoad;
    logic [4:0]  r_rd;
    logic        r_we;
    logic [CW-1:0] r_count;
    logic        r_outValid;
    logic [4:0]  r_outRd;
    logic [31:0] r_outData;
    logic        r_outWe;
    logic        r_misaligned;
    logic        r_busError;

    logic        w_accept;
    logic        w_isMem;
    logic        w_isStore;
    logic        w_signed;
    logic        w_misaligned;
    mem_width_t  w_width;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_loadData;
    logic [1:0]  w_a;

    assign w_accept = IN_VALID && r_inReady;
    assign w_a      = ALU_RESULT[1:0];

    // Decode flags in fixed priority so an illegal multi-flag op still behaves deterministically.
    always_comb begin
        w_isMem      = 1'b1;
        w_isStore    = 1'b0;
        w_signed     = 1'b0;
        w_misaligned = 1'b0;
        w_width      = WIDTH_WORD;
        w_wstrb      = WSTRB_NONE;
        w_wdata      = '0;
        if (CTR_INFO.lw) begin
            w_misaligned = (w_a != 2'b00);
        end else if (CTR_INFO.lh) begin
            w_width = WIDTH_HALF; w_signed = 1'b1; w_misaligned = w_a[0];
        end else if (CTR_INFO.lhu) begin
            w_width = WIDTH_HALF; w_misaligned = w_a[0];
        end else if (CTR_INFO.lb) begin
            w_width = WIDTH_BYTE; w_signed = 1'b1;
        end else if (CTR_INFO.lbu) begin
            w_width = WIDTH_BYTE;
        end else if (CTR_INFO.sw) begin
            w_isStore = 1'b1; w_misaligned = (w_a != 2'b00);
            w_wstrb = WSTRB_WORD; w_wdata = RS2_VAL;
        end else if (CTR_INFO.sh) begin
            w_isStore = 1'b1; w_width = WIDTH_HALF; w_misaligned = w_a[0];
            w_wstrb = w_a[1] ? WSTRB_HALF_HI : WSTRB_HALF_LO;
            w_wdata = {2{RS2_VAL[15:0]}};
        end else if (CTR_INFO.sb) begin
            w_isStore = 1'b1; w_width = WIDTH_BYTE;
            w_wstrb = WSTRB_BYTE << w_a;
            w_wdata = {4{RS2_VAL[7:0]}};
        end else begin
            w_isMem = 1'b0;
        end
    end

    mem_access_load_extend u_loadExtend (
        .i_rdata  (MEM_RDATA),
        .i_offset (r_offset),
        .i_width  (r_width),
        .i_signed (r_signed),
        .o_data   (w_loadData)
    );

    // Result flags are single-cycle pulses; the result fields hold between pulses.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state      <= IDLE;
            r_inReady    <= 1'b0;
            r_memReq     <= 1'b0;
            r_memWe      <= 1'b0;
            r_memAddr    <= '0;
            r_memWstrb   <= '0;
            r_memWdata   <= '0;
            r_offset     <= '0;
            r_width      <= WIDTH_WORD;
            r_signed     <= 1'b0;
            r_isLoad     <= 1'b0;
            r_rd         <= '0;
            r_we         <= 1'b0;
            r_count      <= '0;
            r_outValid   <= 1'b0;
            r_outRd      <= '0;
            r_outData    <= '0;
            r_outWe      <= 1'b0;
            r_misaligned <= 1'b0;
            r_busError   <= 1'b0;
        end else begin
            r_outValid   <= 1'b0;
            r_misaligned <= 1'b0;
            r_busError   <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_inReady <= 1'b1;
                    if (w_accept) begin
                        if (!w_isMem || w_misaligned) begin
                            r_outValid   <= 1'b1;
                            r_outRd      <= IN_RD;
                            r_outData    <= ALU_RESULT;
                            r_outWe      <= IN_WE && !w_isMem;
                            r_misaligned <= w_isMem;
                        end else begin
                            r_state    <= MEM;
                            r_inReady  <= 1'b0;
                            r_memReq   <= 1'b1;
                            r_memWe    <= w_isStore;
                            r_memAddr  <= {ALU_RESULT[31:2], 2'b00};
                            r_memWstrb <= w_wstrb;
                            r_memWdata <= w_wdata;
                            r_offset   <= w_a;
                            r_width    <= w_width;
                            r_signed   <= w_signed;
                            r_isLoad   <= !w_isStore;
                            r_rd       <= IN_RD;
                            r_we       <= IN_WE;
                            r_count    <= '0;
                        end
                    end
                end
                MEM: begin
                    // ACK takes precedence over a timeout reached in the same cycle.
                    if (MEM_ACK) begin
                        r_state    <= IDLE;
                        r_inReady  <= 1'b1;
                        r_memReq   <= 1'b0;
                        r_count    <= '0;
                        r_outValid <= 1'b1;
                        r_outRd    <= r_rd;
                        r_outData  <= r_isLoad ? w_loadData : 32'h0;
                        r_outWe    <= r_isLoad && r_we;
                    end else if (r_count == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_state    <= IDLE;
                        r_inReady  <= 1'b1;
                        r_memReq   <= 1'b0;
                        r_count    <= '0;
                        r_outValid <= 1'b1;
                        r_outRd    <= r_rd;
                        r_outWe    <= 1'b0;
                        r_busError <= 1'b1;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign IN_READY   = r_inReady;
    assign MEM_REQ    = r_memReq;
    assign MEM_WE     = r_memWe;
    assign MEM_ADDR   = r_memAddr;
    assign MEM_WSTRB  = r_memWstrb;
    assign MEM_WDATA  = r_memWdata;
    assign OUT_VALID  = r_outValid;
    assign OUT_RD     = r_outRd;
    assign OUT_DATA   = r_outData;
    assign OUT_WE     = r_outWe;
    assign MISALIGNED = r_misaligned;
    assign BUS_ERROR  = r_busError;

endmodule
